// File: rtl/snd_pkg.sv
// Shared types, widths and the output clamp used by the sound mix sequencer.
package snd_pkg;

  localparam int PCM_W     = 16;
  localparam int VOL_W     = 7;
  localparam int ACC_MAX_W = 20;  // widest accumulator: 16-bit samples summed over up to 8 sources
  localparam logic [PCM_W-1:0] PCM_MID = 16'h8000;

  localparam logic signed [ACC_MAX_W-1:0] SAT_HI = ACC_MAX_W'(32767);
  localparam logic signed [ACC_MAX_W-1:0] SAT_LO = -ACC_MAX_W'(32768);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } mix_state_t;

  function automatic logic [PCM_W-1:0] sat16(input logic signed [ACC_MAX_W-1:0] acc);
    if (acc > SAT_HI)      return 16'h7FFF;
    else if (acc < SAT_LO) return 16'h8000;
    else                   return acc[PCM_W-1:0];
  endfunction

endpackage

// File: rtl/snd_vol_ramp.sv
// DAC volume ramp: moves one step toward the effective target every RAMP_DIV M2 ticks.
import snd_pkg::*;

module snd_vol_ramp #(
  parameter int RAMP_DIV = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [VOL_W-1:0] eff_target,
  output logic [VOL_W-1:0] volume,
  output logic             ramp_busy
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      volume <= '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        // Direction is decided fresh at each step, so a mid-ramp target change never overshoots.
        if (volume < eff_target)      volume <= volume + VOL_W'(1);
        else if (volume > eff_target) volume <= volume - VOL_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign ramp_busy = (volume != eff_target);

endmodule

// File: rtl/snd_mix_ctrl.sv
// Sound mix sequencer: latches per-source samples, sums enabled sources once per M2 fall
// through a single shared adder, clamps to 16 bits and emits offset-binary PCM plus a strobe.
import snd_pkg::*;

module snd_mix_ctrl #(
  parameter int N_SRC    = 4,
  parameter int RAMP_DIV = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m2,
  input  logic [16*N_SRC-1:0]    src_data,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [VOL_W-1:0]       vol_target,
  input  logic                   mute,
  output logic [PCM_W-1:0]       pcm_out,
  output logic                   pcm_strobe,
  output logic [VOL_W-1:0]       volume,
  output logic                   ramp_busy,
  output logic                   overrun
);

  localparam int ACC_W = 17 + $clog2(N_SRC);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SRC - 1);

  logic [2:0]              m2_sync;
  logic                    tick;
  logic [PCM_W-1:0]        hold [N_SRC];
  mix_state_t              state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic [VOL_W-1:0]        eff_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m2_sync <= '0;
    else        m2_sync <= {m2_sync[1:0], m2};
  end

  assign tick = (m2_sync[2:1] == 2'b10);

  // NOTE: sample storage is reset here because a freshly reset mixer must sum to silence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (src_valid[i]) hold[i] <= src_data[16*i +: 16];
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    addend = '0;
    if (src_en[idx]) addend = {{(ACC_W-PCM_W){hold[idx][PCM_W-1]}}, hold[idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      pcm_out    <= PCM_MID;
      pcm_strobe <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pcm_strobe <= 1'b0;
      // Ticks arriving mid-mix are dropped, only flagged.
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            acc   <= '0;
            idx   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + addend;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_LAST) state <= SAT;
        end
        SAT: begin
          pcm_out    <= sat16(ACC_MAX_W'(acc)) ^ PCM_MID;
          pcm_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eff_target = mute ? '0 : vol_target;

  snd_vol_ramp #(
    .RAMP_DIV (RAMP_DIV)
  ) u_vol_ramp (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .eff_target (eff_target),
    .volume     (volume),
    .ramp_busy  (ramp_busy)
  );

endmodule

// File: tb/tb_snd_mix_ctrl.sv
// Directed and randomized bench for snd_mix_ctrl, checked against an arithmetic reference model.
module tb_snd_mix_ctrl;

  localparam int N  = 4;
  localparam int RD = 2;

  logic          clk;
  logic          rst_n;
  logic          m2;
  logic [16*N-1:0] src_data;
  logic [N-1:0]  src_valid;
  logic [N-1:0]  src_en;
  logic [6:0]    vol_target;
  logic          mute;
  logic [15:0]   pcm_out;
  logic          pcm_strobe;
  logic [6:0]    volume;
  logic          ramp_busy;
  logic          overrun;

  snd_mix_ctrl #(.N_SRC(N), .RAMP_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m2         (m2),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_en     (src_en),
    .vol_target (vol_target),
    .mute       (mute),
    .pcm_out    (pcm_out),
    .pcm_strobe (pcm_strobe),
    .volume     (volume),
    .ramp_busy  (ramp_busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_hold [N];
  int          m_cnt;
  int          m_vol;
  bit          m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mix_ref(input logic [15:0] h [N], input logic [N-1:0] en);
    int s;
    int v;
    s = 0;
    for (int i = 0; i < N; i++) begin
      v = $signed(h[i]);
      if (en[i]) s += v;
    end
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s) ^ 16'h8000;
  endfunction

  function automatic int eff_ref();
    return mute ? 0 : int'(vol_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_hold[i] = '0;
    m_cnt = 0;
    m_vol = 0;
    m_ovr = 0;
  endtask

  task automatic model_tick();
    int eff;
    eff = eff_ref();
    m_cnt++;
    if (m_cnt == RD) begin
      m_cnt = 0;
      if (m_vol < eff)      m_vol++;
      else if (m_vol > eff) m_vol--;
    end
  endtask

  task automatic load(input int i, input logic [15:0] v);
    src_data[16*i +: 16] = v;
    src_valid    = '0;
    src_valid[i] = 1'b1;
    @(negedge clk);
    src_valid = '0;
    m_hold[i] = v;
  endtask

  task automatic check_side(input string tag);
    check({tag, "_volume"}, 32'(volume), 32'(m_vol));
    check({tag, "_busy"}, 32'(ramp_busy), 32'(m_vol != eff_ref()));
    check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
  endtask

  // One M2 frame. ld_at>0 loads ld_val into source ld_src at that many clks after the M2 fall;
  // dbl injects a second M2 fall while the mix is still running.
  task automatic frame(input string tag, input int ld_at, input int ld_src,
                       input logic [15:0] ld_val, input bit dbl);
    logic [15:0] h [N];
    logic [15:0] exp;
    int lat;
    bit got;
    h = m_hold;
    // Source i is read 3+i clks after the fall; a load landing before that is seen.
    if (ld_at > 0 && ld_at <= 2 + ld_src) h[ld_src] = ld_val;
    exp = mix_ref(h, src_en);
    m2 = 1'b1;
    repeat (4) @(negedge clk);
    m2 = 1'b0;
    model_tick();
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ld_at > 0 && lat == ld_at + 1) src_valid = '0;
      if (ld_at > 0 && lat == ld_at) begin
        src_data[16*ld_src +: 16] = ld_val;
        src_valid[ld_src] = 1'b1;
      end
      if (dbl && lat == 3) m2 = 1'b1;
      if (dbl && lat == 5) begin
        m2 = 1'b0;
        model_tick();
        m_ovr = 1;
      end
      if (pcm_strobe) got = 1;
    end
    src_valid = '0;
    if (ld_at > 0) m_hold[ld_src] = ld_val;
    check({tag, "_strobe_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_pcm"}, 32'(pcm_out), 32'(exp));
    @(negedge clk);
    check({tag, "_strobe_width"}, 32'(pcm_strobe), 32'd0);
    check_side(tag);
  endtask

  initial begin
    int extra;
    rst_n      = 1'b0;
    m2         = 1'b0;
    src_data   = '0;
    src_valid  = '0;
    src_en     = '0;
    vol_target = '0;
    mute       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pcm", 32'(pcm_out), 32'h8000);
    check("rst_strobe", 32'(pcm_strobe), 32'd0);
    check("rst_volume", 32'(volume), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    rst_n      = 1'b1;
    vol_target = 7'd3;
    @(negedge clk);

    // Mixed sum with a negative contributor
    src_en = 4'hF;
    load(0, 16'h1000);
    load(1, 16'h2000);
    load(2, 16'h0100);
    load(3, 16'hFF00);
    frame("mix_sum", 0, 0, '0, 0);

    // Saturation in both directions
    for (int i = 0; i < N; i++) load(i, 16'h7000);
    frame("sat_pos", 0, 0, '0, 0);
    check("sat_pos_value", 32'(pcm_out), 32'h0000FFFF);
    for (int i = 0; i < N; i++) load(i, 16'h9000);
    frame("sat_neg", 0, 0, '0, 0);
    check("sat_neg_value", 32'(pcm_out), 32'h00000000);

    // Enable mask and same-cycle load hazard
    src_en = 4'b0001;
    load(0, 16'h1234);
    for (int i = 1; i < N; i++) load(i, 16'h7FFF);
    frame("en_mask", 0, 0, '0, 0);
    check("en_mask_value", 32'(pcm_out), 32'h00009234);
    frame("hazard", 3, 0, 16'h0001, 0);
    check("hazard_value", 32'(pcm_out), 32'h00009234);
    frame("hazard_next", 0, 0, '0, 0);
    check("hazard_next_value", 32'(pcm_out), 32'h00008001);

    // Six ticks at two ticks per step reach the target of 3
    check("ramp_up_done", 32'(volume), 32'd3);
    check("ramp_up_idle", 32'(ramp_busy), 32'd0);

    mute = 1'b1;
    for (int i = 0; i < 6; i++) frame("mute", 0, 0, '0, 0);
    check("mute_done", 32'(volume), 32'd0);
    mute = 1'b0;

    // Randomized frames: random targets, masks, repeated and mid-frame loads
    for (int f = 0; f < 12; f++) begin
      vol_target = 7'($urandom_range(0, 127));
      src_en     = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) load(i, 16'($urandom));
        if ($urandom_range(0, 3) == 0) load(i, 16'($urandom));
      end
      if ($urandom_range(0, 1) == 1)
        frame("rand", $urandom_range(1, 7), $urandom_range(0, N - 1), 16'($urandom), 0);
      else
        frame("rand", 0, 0, '0, 0);
    end

    // Overrun: second fall during the mix is dropped and latched
    vol_target = 7'd127;
    src_en     = 4'hF;
    frame("overrun", 0, 0, '0, 1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pcm_strobe) extra++;
    end
    check("overrun_no_extra_strobe", 32'(extra), 32'd0);
    check("overrun_set", 32'(overrun), 32'd1);
    frame("overrun_sticky", 0, 0, '0, 0);

    // Reset while accumulating
    m2 = 1'b1;
    repeat (4) @(negedge clk);
    m2 = 1'b0;
    model_tick();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_pcm", 32'(pcm_out), 32'h8000);
    check("midrst_strobe", 32'(pcm_strobe), 32'd0);
    check_side("midrst");
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pcm_strobe) extra++;
    end
    check("midrst_no_strobe", 32'(extra), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    frame("post_reset", 0, 0, '0, 0);
    check("post_reset_silence", 32'(pcm_out), 32'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
